// File: rtl/chip_config_pkg.sv
// Shared chip configuration constants: CSR address map, ID word and access FSM states.
package chip_config_pkg;

    localparam logic [2:0] CSR_EN_ADDR     = 3'd0;
    localparam logic [2:0] CSR_TYPE_ADDR   = 3'd1;
    localparam logic [2:0] CSR_ACT_ADDR    = 3'd2;
    localparam logic [2:0] CSR_STICKY_ADDR = 3'd3;
    localparam logic [2:0] CSR_MASK_ADDR   = 3'd4;
    localparam logic [2:0] CSR_ID_ADDR     = 3'd5;

    localparam logic [31:0] CSR_ID = 32'h0B0F_0001;

    typedef enum logic {
        IDLE,
        ACK
    } csr_state_e;

endpackage

// File: rtl/csr_sync2.sv
// One-bit two-flop synchroniser for signals asynchronous to clk.
module csr_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/buf_csr_ctrl.sv
// Control/status registers for a buffer bank: enable/polarity drive, synchronised
// activity detect with sticky edge capture and a maskable level interrupt.
module buf_csr_ctrl
    import chip_config_pkg::*;
#(
    parameter int unsigned       NUM_CH   = 8,
    parameter logic [NUM_CH-1:0] TYPE_RST = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [NUM_CH-1:0] bufen,
    output logic [NUM_CH-1:0] buftype,
    input  logic [NUM_CH-1:0] actdet,
    output logic              irq
);

    csr_state_e state_q, state_d;

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] type_q, type_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [NUM_CH-1:0] act_prev_q;
    logic [NUM_CH-1:0] act_sync;
    logic [NUM_CH-1:0] act_rise;
    logic [NUM_CH-1:0] sticky_clr;
    logic [NUM_CH-1:0] wdata_ch;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       rd_word;
    logic              access;
    logic              wr;
    logic              unmapped;
    logic              unused_wdata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        csr_sync2 u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (actdet[i]),
            .q     (act_sync[i])
        );
    end

    assign access       = (state_q == IDLE) && req;
    assign wr           = access && we;
    assign unmapped     = (addr > CSR_ID_ADDR);
    assign wdata_ch     = wdata[NUM_CH-1:0];
    assign unused_wdata = ^wdata;
    assign act_rise     = act_sync & ~act_prev_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d       = en_q;
        type_d     = type_q;
        mask_d     = mask_q;
        sticky_clr = '0;
        if (wr) begin
            case (addr)
                CSR_EN_ADDR:     en_d       = wdata_ch;
                CSR_TYPE_ADDR:   type_d     = wdata_ch;
                CSR_STICKY_ADDR: sticky_clr = wdata_ch;
                CSR_MASK_ADDR:   mask_d     = wdata_ch;
                default: ;
            endcase
        end
        // A fresh edge in the same cycle as a clear keeps the bit set.
        sticky_d = (sticky_q & ~sticky_clr) | act_rise;
        irq_d    = |(sticky_q & mask_q);
    end

    always_comb begin
        rd_word = '0;
        case (addr)
            CSR_EN_ADDR:     rd_word[NUM_CH-1:0] = en_q;
            CSR_TYPE_ADDR:   rd_word[NUM_CH-1:0] = type_q;
            CSR_ACT_ADDR:    rd_word[NUM_CH-1:0] = act_sync;
            CSR_STICKY_ADDR: rd_word[NUM_CH-1:0] = sticky_q;
            CSR_MASK_ADDR:   rd_word[NUM_CH-1:0] = mask_q;
            CSR_ID_ADDR:     rd_word             = CSR_ID;
            default: ;
        endcase
        // No access is taken in ACK, so the response registers clear as ACK ends.
        rdata_d = (access && !we && !unmapped) ? rd_word : '0;
        err_d   = access && unmapped;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= '0;
            type_q     <= TYPE_RST;
            mask_q     <= '0;
            sticky_q   <= '0;
            act_prev_q <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            type_q     <= type_d;
            mask_q     <= mask_d;
            sticky_q   <= sticky_d;
            act_prev_q <= act_sync;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign ack     = (state_q == ACK);
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign bufen   = en_q;
    assign buftype = type_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_buf_csr_ctrl.sv
// Self-checking bench for buf_csr_ctrl: vector table with a response scoreboard plus
// hand-timed sequences for sticky/irq latency, set-beats-clear and reset mid-access.
module tb_buf_csr_ctrl;

    localparam int unsigned NUM_CH = 8;
    localparam logic [31:0] ID_WORD = 32'h0B0F_0001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [2:0]        addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;
    logic [NUM_CH-1:0] bufen;
    logic [NUM_CH-1:0] buftype;
    logic [NUM_CH-1:0] actdet;
    logic              irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_bufen;
        logic [7:0]  exp_buftype;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    buf_csr_ctrl #(
        .NUM_CH   (NUM_CH),
        .TYPE_RST ('1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .err     (err),
        .bufen   (bufen),
        .buftype (buftype),
        .actdet  (actdet),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ee,
                                input logic [7:0] eb, input logic [7:0] et);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
        v.exp_bufen = eb; v.exp_buftype = et;
        return v;
    endfunction

    // Drives one access after 1+pre falling edges; expectation queued at drive time
    // and checked when ack is observed.
    task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee, input int pre);
        exp_t e;
        exp_t got_e;
        bit   got;
        e.rdata = er;
        e.err   = ee;
        @(negedge clk);
        for (int i = 0; i < pre; i++) @(negedge clk);
        exp_q.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 10 cycles (addr %0d)", a);
            void'(exp_q.pop_front());
        end else begin
            got_e = exp_q.pop_front();
            chk($sformatf("rdata_a%0d", a), rdata, got_e.rdata);
            chk($sformatf("err_a%0d", a), {31'b0, err}, {31'b0, got_e.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; actdet = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_bufen", {24'b0, bufen}, 32'h00);
        chk("rst_buftype", {24'b0, buftype}, 32'hFF);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;

        // Reset read-back of the whole map.
        vecs.push_back(mk(0, 3'd0, 0, 32'h00, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd1, 0, 32'hFF, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd2, 0, 32'h00, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd3, 0, 32'h00, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd4, 0, 32'h00, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd5, 0, ID_WORD, 0, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd6, 0, 32'h00, 1, 8'h00, 8'hFF));
        vecs.push_back(mk(0, 3'd7, 0, 32'h00, 1, 8'h00, 8'hFF));
        // Writes, upper bits dropped, RO/W1C/unmapped writes leave state alone.
        vecs.push_back(mk(1, 3'd0, 32'h1234_56A5, 32'h00, 0, 8'hA5, 8'hFF));
        vecs.push_back(mk(1, 3'd1, 32'h0000_000F, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd0, 0, 32'hA5, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd1, 0, 32'h0F, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 3'd2, 32'hFF, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 3'd3, 32'hFF, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd3, 0, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd2, 0, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 3'd7, 32'h5A, 32'h00, 1, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 3'd6, 32'h5A, 32'h00, 1, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd0, 0, 32'hA5, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd1, 0, 32'h0F, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(1, 3'd4, 32'hFFFF_FF3C, 32'h00, 0, 8'hA5, 8'h0F));
        vecs.push_back(mk(0, 3'd4, 0, 32'h3C, 0, 8'hA5, 8'h0F));

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   vecs[i].exp_err, 0);
            chk($sformatf("v%0d_bufen", i), {24'b0, bufen}, {24'b0, vecs[i].exp_bufen});
            chk($sformatf("v%0d_buftype", i), {24'b0, buftype}, {24'b0, vecs[i].exp_buftype});
            chk($sformatf("v%0d_irq", i), {31'b0, irq}, 32'd0);
        end

        // req held high: ack on alternate cycles, rdata zero between acks.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("tput_ack%0d", i), {31'b0, ack}, {31'b0, (i % 2 == 0)});
            chk($sformatf("tput_rdata%0d", i), rdata, (i % 2 == 0) ? ID_WORD : 32'd0);
        end
        req = 1'b0;

        // Sticky capture and irq latency on channel 3.
        access(1, 3'd4, 32'h08, 32'h00, 0, 0);
        @(negedge clk);
        actdet[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_before", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        actdet[3] = 1'b0;
        access(0, 3'd3, 0, 32'h08, 0, 0);
        access(1, 3'd3, 32'h08, 32'h00, 0, 0);
        chk("irq_at_ack", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_fall", {31'b0, irq}, 32'd0);
        access(0, 3'd3, 0, 32'h00, 0, 0);

        // W1C sampled on the same edge as a fresh synchronised rising edge.
        repeat (3) @(negedge clk);
        actdet[3] = 1'b1;
        access(1, 3'd3, 32'h08, 32'h00, 0, 1);
        access(0, 3'd3, 0, 32'h08, 0, 0);
        access(0, 3'd2, 0, 32'h08, 0, 0);
        actdet[3] = 1'b0;
        repeat (4) @(negedge clk);
        access(1, 3'd3, 32'h08, 32'h00, 0, 0);
        access(0, 3'd3, 0, 32'h00, 0, 0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);

        // Reset asserted during the ACK cycle of an EN write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h33;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("rstmid_ack", {31'b0, ack}, 32'd0);
        chk("rstmid_bufen", {24'b0, bufen}, 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ack_after", {31'b0, ack}, 32'd0);
        chk("rstmid_buftype", {24'b0, buftype}, 32'hFF);
        access(0, 3'd0, 0, 32'h00, 0, 0);
        access(0, 3'd1, 0, 32'hFF, 0, 0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
